control_sequencer: RTL and testbench

Hardwired control unit for the 8-bit CPU datapath: ALUSystem with register file, address register file (ARF), ALU, IR, memory and muxes. It owns the one-hot timing counter `T`. Each instruction is fetched as two bytes into IR. The block then decodes `IROut` and drives every datapath control field cycle by cycle until the instruction completes. It instantiates inside CPUSystem, next to ALUSystem.

---
 rtl/control_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 8-bit ALUSystem datapath.
// It steps a one-hot timing register through a two-byte fetch (T0, T1) and
// then one or two execute cycles (T2, T3). Every datapath control field is
// decoded combinationally from the timing state and the held instruction.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [7:0]  T,
  output logic        Halted,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel
);

  // Timing states. HALT is the all-zero pattern; every other state is one-hot.
  typedef enum logic [7:0] {
    T_HALT = 8'h00,
    T_0    = 8'h01,
    T_1    = 8'h02,
    T_2    = 8'h04,
    T_3    = 8'h08
  } t_state_e;

  // Opcodes held in IROut[15:12].
  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_DEC = 4'h5;
  localparam logic [3:0] OP_BRA = 4'h6;
  localparam logic [3:0] OP_BNE = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Register operation codes shared by RF, ARF and IR.
  localparam logic [1:0] FN_DEC  = 2'b00;
  localparam logic [1:0] FN_INC  = 2'b01;
  localparam logic [1:0] FN_LOAD = 2'b10;

  // Datapath select encodings.
  localparam logic [3:0] ARF_PC      = 4'b1000;
  localparam logic [3:0] ARF_AR      = 4'b0100;
  localparam logic [1:0] OUTB_AR     = 2'b01;
  localparam logic [1:0] MUXA_MEM    = 2'b01;
  localparam logic [1:0] MUXA_IR     = 2'b10;
  localparam logic [1:0] MUXB_IR     = 2'b01;
  localparam logic [3:0] ALU_ADD     = 4'b0100;

  t_state_e t_q, t_d;

  logic [3:0] opcode;
  logic [1:0] rx;
  logic [1:0] ry;
  logic       flag_z;
  logic [3:0] rx_onehot;

  assign opcode    = IROut[15:12];
  assign rx        = IROut[11:10];
  assign ry        = IROut[9:8];
  assign flag_z    = ALUOutFlag[3];
  assign rx_onehot = 4'b1000 >> rx;

  // The address byte and the C/N/O flags feed the datapath directly, not this block.
  logic unused_inputs;
  assign unused_inputs = ^{IROut[7:0], ALUOutFlag[2:0]};

  // Timing state register; reset lands directly in T0.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      t_q <= T_0;
    end else begin
      t_q <= t_d;
    end
  end

  assign T      = t_q;
  assign Halted = (t_q == T_HALT);

  // Next-state and control-field decode; everything is idle unless a state drives it.
  // NOTE: every output gets its idle value first so no path through the case infers a latch.
  always_comb begin
    t_d         = t_q;
    RF_O1Sel    = 3'b000;
    RF_O2Sel    = 3'b000;
    RF_FunSel   = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutASel = 2'b00;
    ARF_OutBSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;

    // While Reset is high the state reads T0 but no memory access may happen.
    if (!Reset) begin
      case (t_q)
        T_0, T_1: begin
          // Fetch one byte from M[PC] into IR and advance PC.
          Mem_CS      = 1'b0;
          ARF_OutBSel = 2'b00;
          IR_Enable   = 1'b1;
          IR_LH       = (t_q == T_1);
          IR_Funsel   = FN_LOAD;
          ARF_RegSel  = ARF_PC;
          ARF_FunSel  = FN_INC;
          t_d         = (t_q == T_0) ? T_1 : T_2;
        end

        T_2: begin
          t_d = T_0;
          case (opcode)
            OP_LDI: begin
              RF_RSel   = rx_onehot;
              RF_FunSel = FN_LOAD;
              MuxASel   = MUXA_IR;
            end
            OP_LD, OP_ST: begin
              ARF_RegSel = ARF_AR;
              ARF_FunSel = FN_LOAD;
              MuxBSel    = MUXB_IR;
              t_d        = T_3;
            end
            OP_ADD: begin
              RF_O1Sel   = {1'b1, rx};
              RF_O2Sel   = {1'b1, ry};
              ALU_FunSel = ALU_ADD;
              MuxASel    = 2'b00;
              RF_RSel    = rx_onehot;
              RF_FunSel  = FN_LOAD;
            end
            OP_INC: begin
              RF_RSel   = rx_onehot;
              RF_FunSel = FN_INC;
            end
            OP_DEC: begin
              RF_RSel   = rx_onehot;
              RF_FunSel = FN_DEC;
            end
            OP_BRA: begin
              ARF_RegSel = ARF_PC;
              ARF_FunSel = FN_LOAD;
              MuxBSel    = MUXB_IR;
            end
            OP_BNE: begin
              if (!flag_z) begin
                ARF_RegSel = ARF_PC;
                ARF_FunSel = FN_LOAD;
                MuxBSel    = MUXB_IR;
              end
            end
            OP_HLT: begin
              t_d = T_HALT;
            end
            default: begin
              // 8..E are NOPs: idle for one cycle.
            end
          endcase
        end

        T_3: begin
          t_d = T_0;
          case (opcode)
            OP_LD: begin
              Mem_CS      = 1'b0;
              ARF_OutBSel = OUTB_AR;
              MuxASel     = MUXA_MEM;
              RF_RSel     = rx_onehot;
              RF_FunSel   = FN_LOAD;
            end
            OP_ST: begin
              RF_O1Sel    = {1'b1, rx};
              MuxCSel     = 1'b0;
              ALU_FunSel  = 4'b0000;
              ARF_OutBSel = OUTB_AR;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            default: begin
              // Only LD and ST have a T3; anything else just returns to fetch.
            end
          endcase
        end

        T_HALT: begin
          t_d = T_HALT;
        end

        default: begin
          // Not a legal one-hot pattern: recover by restarting the fetch.
          t_d = T_0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through
// fetch and execute, checks HALT and both reset scenarios against hand-derived
// control field values. Outputs are sampled on the falling clock edge.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [7:0]  T;
  logic        Halted;
  logic [2:0]  RF_O1Sel;
  logic [2:0]  RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel;
  logic [3:0]  RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutASel;
  logic [1:0]  ARF_OutBSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .IROut      (IROut),
    .ALUOutFlag (ALUOutFlag),
    .T          (T),
    .Halted     (Halted),
    .RF_O1Sel   (RF_O1Sel),
    .RF_O2Sel   (RF_O2Sel),
    .RF_FunSel  (RF_FunSel),
    .RF_RSel    (RF_RSel),
    .RF_TSel    (RF_TSel),
    .ALU_FunSel (ALU_FunSel),
    .ARF_OutASel(ARF_OutASel),
    .ARF_OutBSel(ARF_OutBSel),
    .ARF_FunSel (ARF_FunSel),
    .ARF_RegSel (ARF_RegSel),
    .IR_LH      (IR_LH),
    .IR_Enable  (IR_Enable),
    .IR_Funsel  (IR_Funsel),
    .Mem_WR     (Mem_WR),
    .Mem_CS     (Mem_CS),
    .MuxASel    (MuxASel),
    .MuxBSel    (MuxBSel),
    .MuxCSel    (MuxCSel)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the following falling edge.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Fields that must be idle whenever no state drives them.
  task automatic check_idle(input string tag);
    check({tag, " Mem_CS"},     {15'd0, Mem_CS},     16'h1);
    check({tag, " Mem_WR"},     {15'd0, Mem_WR},     16'h0);
    check({tag, " IR_Enable"},  {15'd0, IR_Enable},  16'h0);
    check({tag, " ARF_RegSel"}, {12'd0, ARF_RegSel}, 16'h0);
    check({tag, " RF_RSel"},    {12'd0, RF_RSel},    16'h0);
    check({tag, " MuxBSel"},    {14'd0, MuxBSel},    16'h0);
  endtask

  // Starting at T0: check both fetch cycles, present the instruction, land in T2.
  task automatic fetch(input logic [15:0] ir, input string tag);
    check({tag, " T0 T"},          {8'd0, T},            16'h01);
    check({tag, " T0 Mem_CS"},     {15'd0, Mem_CS},      16'h0);
    check({tag, " T0 OutBSel"},    {14'd0, ARF_OutBSel}, 16'h0);
    check({tag, " T0 IR_Enable"},  {15'd0, IR_Enable},   16'h1);
    check({tag, " T0 IR_LH"},      {15'd0, IR_LH},       16'h0);
    check({tag, " T0 IR_Funsel"},  {14'd0, IR_Funsel},   16'h2);
    check({tag, " T0 ARF_RegSel"}, {12'd0, ARF_RegSel},  16'h8);
    check({tag, " T0 ARF_FunSel"}, {14'd0, ARF_FunSel},  16'h1);
    tick();
    check({tag, " T1 T"},          {8'd0, T},            16'h02);
    check({tag, " T1 IR_LH"},      {15'd0, IR_LH},       16'h1);
    check({tag, " T1 Mem_CS"},     {15'd0, Mem_CS},      16'h0);
    check({tag, " T1 ARF_RegSel"}, {12'd0, ARF_RegSel},  16'h8);
    IROut = ir;
    tick();
    check({tag, " T2 T"},          {8'd0, T},            16'h04);
  endtask

  initial begin
    Reset      = 1'b1;
    IROut      = 16'h0000;
    ALUOutFlag = 4'b0000;

    // Reset held: T0 pattern but everything forced idle.
    #3;
    check("rst T",      {8'd0, T},       16'h01);
    check("rst Halted", {15'd0, Halted}, 16'h0);
    check_idle("rst");
    @(negedge Clock);
    check("rst held T", {8'd0, T},       16'h01);
    check_idle("rst held");
    Reset = 1'b0;
    #1;

    // LDI R2,0x5A
    fetch(16'h045A, "LDI");
    check("LDI RF_RSel",   {12'd0, RF_RSel},   16'h4);
    check("LDI RF_FunSel", {14'd0, RF_FunSel}, 16'h2);
    check("LDI MuxASel",   {14'd0, MuxASel},   16'h2);
    check("LDI Mem_CS",    {15'd0, Mem_CS},    16'h1);
    check("LDI IR_Enable", {15'd0, IR_Enable}, 16'h0);
    tick();
    check("LDI end T", {8'd0, T}, 16'h01);

    // LD R1,[0x20]
    fetch(16'h1020, "LD");
    check("LD T2 ARF_RegSel", {12'd0, ARF_RegSel}, 16'h4);
    check("LD T2 ARF_FunSel", {14'd0, ARF_FunSel}, 16'h2);
    check("LD T2 MuxBSel",    {14'd0, MuxBSel},    16'h1);
    check("LD T2 RF_RSel",    {12'd0, RF_RSel},    16'h0);
    check("LD T2 Mem_CS",     {15'd0, Mem_CS},     16'h1);
    tick();
    check("LD T3 T",          {8'd0, T},           16'h08);
    check("LD T3 Mem_CS",     {15'd0, Mem_CS},     16'h0);
    check("LD T3 Mem_WR",     {15'd0, Mem_WR},     16'h0);
    check("LD T3 OutBSel",    {14'd0, ARF_OutBSel}, 16'h1);
    check("LD T3 MuxASel",    {14'd0, MuxASel},    16'h1);
    check("LD T3 RF_RSel",    {12'd0, RF_RSel},    16'h8);
    check("LD T3 RF_FunSel",  {14'd0, RF_FunSel},  16'h2);
    check("LD T3 ARF_RegSel", {12'd0, ARF_RegSel}, 16'h0);
    tick();
    check("LD end T", {8'd0, T}, 16'h01);

    // ADD R1,R2
    fetch(16'h3100, "ADD");
    check("ADD O1Sel",     {13'd0, RF_O1Sel},   16'h4);
    check("ADD O2Sel",     {13'd0, RF_O2Sel},   16'h5);
    check("ADD ALU",       {12'd0, ALU_FunSel}, 16'h4);
    check("ADD MuxASel",   {14'd0, MuxASel},    16'h0);
    check("ADD RF_RSel",   {12'd0, RF_RSel},    16'h8);
    check("ADD RF_FunSel", {14'd0, RF_FunSel},  16'h2);
    tick();
    check("ADD end T", {8'd0, T}, 16'h01);

    // INC on Rx = 3
    fetch(16'h4C00, "INC");
    check("INC RF_RSel",   {12'd0, RF_RSel},   16'h1);
    check("INC RF_FunSel", {14'd0, RF_FunSel}, 16'h1);
    tick();
    check("INC end T", {8'd0, T}, 16'h01);

    // DEC on Rx = 1
    fetch(16'h5400, "DEC");
    check("DEC RF_RSel",   {12'd0, RF_RSel},   16'h4);
    check("DEC RF_FunSel", {14'd0, RF_FunSel}, 16'h0);
    tick();
    check("DEC end T", {8'd0, T}, 16'h01);

    // BRA 0x33
    fetch(16'h6033, "BRA");
    check("BRA ARF_RegSel", {12'd0, ARF_RegSel}, 16'h8);
    check("BRA ARF_FunSel", {14'd0, ARF_FunSel}, 16'h2);
    check("BRA MuxBSel",    {14'd0, MuxBSel},    16'h1);
    tick();
    check("BRA end T", {8'd0, T}, 16'h01);

    // BNE 0x10 with Z = 1: not taken, all idle.
    ALUOutFlag = 4'b1000;
    fetch(16'h7010, "BNEz");
    check_idle("BNEz T2");
    check("BNEz ARF_FunSel", {14'd0, ARF_FunSel}, 16'h0);
    tick();
    check("BNEz end T", {8'd0, T}, 16'h01);

    // BNE 0x10 with Z = 0: taken.
    ALUOutFlag = 4'b0000;
    fetch(16'h7010, "BNEt");
    check("BNEt ARF_RegSel", {12'd0, ARF_RegSel}, 16'h8);
    check("BNEt ARF_FunSel", {14'd0, ARF_FunSel}, 16'h2);
    check("BNEt MuxBSel",    {14'd0, MuxBSel},    16'h1);
    tick();
    check("BNEt end T", {8'd0, T}, 16'h01);

    // NOP (opcode 9)
    fetch(16'h9000, "NOP");
    check_idle("NOP T2");
    tick();
    check("NOP end T", {8'd0, T}, 16'h01);

    // ST R3,[0x30] with reset pulsed between edges during T3.
    fetch(16'h2830, "ST");
    check("ST T2 ARF_RegSel", {12'd0, ARF_RegSel}, 16'h4);
    check("ST T2 MuxBSel",    {14'd0, MuxBSel},    16'h1);
    tick();
    check("ST T3 T",        {8'd0, T},            16'h08);
    check("ST T3 Mem_CS",   {15'd0, Mem_CS},      16'h0);
    check("ST T3 Mem_WR",   {15'd0, Mem_WR},      16'h1);
    check("ST T3 O1Sel",    {13'd0, RF_O1Sel},    16'h6);
    check("ST T3 OutBSel",  {14'd0, ARF_OutBSel}, 16'h1);
    check("ST T3 ALU",      {12'd0, ALU_FunSel},  16'h0);
    check("ST T3 RF_RSel",  {12'd0, RF_RSel},     16'h0);
    Reset = 1'b1;
    #1;
    check("ST rst T",      {8'd0, T},       16'h01);
    check("ST rst Mem_CS", {15'd0, Mem_CS}, 16'h1);
    check("ST rst Mem_WR", {15'd0, Mem_WR}, 16'h0);
    check("ST rst Halted", {15'd0, Halted}, 16'h0);
    #1;
    Reset = 1'b0;
    #1;

    // HLT after the abandoned ST; this fetch also proves T0 resumes from PC.
    fetch(16'hF000, "HLT");
    check_idle("HLT T2");
    tick();
    for (int i = 0; i < 20; i++) begin
      check("HALT T",      {8'd0, T},       16'h00);
      check("HALT Halted", {15'd0, Halted}, 16'h1);
      check_idle("HALT");
      tick();
    end
    Reset = 1'b1;
    #1;
    check("HALT rst T",      {8'd0, T},       16'h01);
    check("HALT rst Halted", {15'd0, Halted}, 16'h0);
    check("HALT rst Mem_CS", {15'd0, Mem_CS}, 16'h1);
    #1;
    Reset = 1'b0;
    #1;
    check("post rst Mem_CS",    {15'd0, Mem_CS},    16'h0);
    check("post rst IR_Enable", {15'd0, IR_Enable}, 16'h1);
    tick();
    check("post rst T", {8'd0, T}, 16'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
